// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: default width and the
// ALU control codes from which the execute stage derives start/is_signed.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  // ALU control codes that route an instruction to the divider.
  localparam logic [3:0] DIV_CONTROL  = 4'b1010;
  localparam logic [3:0] DIVU_CONTROL = 4'b1011;

endpackage

// File: rtl/div_unit_if.sv
// Handshake/operand bundle between the execute stage and the divider.
interface div_unit_if #(parameter int WIDTH = 32);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  modport master (
    output start, is_signed, a, b, flush,
    input  busy, done, quo, rem
  );

  modport slave (
    input  start, is_signed, a, b, flush,
    output busy, done, quo, rem
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift the remainder/quotient register
// left, trial-subtract the divisor from the upper field, keep or restore.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0] rq_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] rq_out
);

  // The trial keeps one extra top bit so the bit shifted out of the
  // register still takes part in the comparison; its MSB is the sign.
  logic [WIDTH+1:0] trial;

  // Shift, subtract, and pick the quotient bit in a single combinational pass.
  always_comb begin
    trial = {rq_in[2*WIDTH:WIDTH], rq_in[WIDTH-1]} - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rq_out = {trial[WIDTH:0], rq_in[WIDTH-2:0], 1'b1};
    end else begin
      rq_out = {rq_in[2*WIDTH-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with busy/done handshake.
// Magnitudes are divided unsigned; signs and divide-by-zero are applied in FIX.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH:0] rq_q, rq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             bzero_q, bzero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [2*WIDTH:0] rq_step;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] q_mag, r_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq_in   (rq_q),
    .divisor (dvs_q),
    .rq_out  (rq_step)
  );

  // Next-state, operand capture, iteration and result fix-up.
  always_comb begin
    a_neg = bus.is_signed & bus.a[WIDTH-1];
    b_neg = bus.is_signed & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
    q_mag = rq_q[WIDTH-1:0];
    r_mag = rq_q[2*WIDTH-1:WIDTH];

    state_d    = state_q;
    cnt_d      = cnt_q;
    rq_d       = rq_q;
    dvs_d      = dvs_q;
    a_raw_d    = a_raw_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    bzero_d    = bzero_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    quo_d      = quo_q;
    rem_d      = rem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          rq_d       = {{(WIDTH+1){1'b0}}, a_mag};
          dvs_d      = b_mag;
          a_raw_d    = bus.a;
          sign_quo_d = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          sign_rem_d = a_neg;
          bzero_d    = (bus.b == '0);
          busy_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rq_d   = rq_step;
        cnt_d  = cnt_q + 1'b1;
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (bzero_q) begin
          quo_d = '1;
          rem_d = a_raw_q;
        end else begin
          quo_d = sign_quo_q ? -q_mag : q_mag;
          rem_d = sign_rem_q ? -r_mag : r_mag;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush cancels everything in flight, including a same-cycle start.
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      quo_d   = quo_q;
      rem_d   = rem_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rq_q       <= '0;
      dvs_q      <= '0;
      a_raw_q    <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      bzero_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rq_q       <= rq_d;
      dvs_q      <= dvs_d;
      a_raw_q    <= a_raw_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      bzero_q    <= bzero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider for the execute stage. The ALU decoder produces a DIV or DIVU control code, and the execute stage turns that code into a `start` pulse plus operands for this block. The block computes the quotient and remainder over WIDTH iterations and reports through a busy/done handshake, so the pipeline can stall until HI/LO are ready to write.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.

- `clk` in 1: rising-edge clock.
- `resetn` in 1: reset, asynchronous and active-low. One clock; all state resets asynchronously on `resetn` low.
- `start` in 1: begin a division. Sampled only in IDLE or DONE.
- `is_signed` in 1: 1 selects DIV, 0 selects DIVU. Sampled with `start`.
- `a` in WIDTH: dividend. Sampled with `start`.
- `b` in WIDTH: divisor. Sampled with `start`.
- `flush` in 1: synchronous cancel of an operation in flight.
- `busy` out 1: high in RUN and FIX. The pipeline stalls on it.
- `done` out 1: one-cycle pulse when `quo` and `rem` become valid.
- `quo` out WIDTH: quotient. Holds its value until the next completed operation.
- `rem` out WIDTH: remainder. Holds its value until the next completed operation.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: WIDTH iterations.
  - FIX: sign correction and divide-by-zero handling.
  - DONE: one cycle, `done` = 1.
- Transitions:
  - IDLE to RUN on `start`.
  - RUN to FIX when the iteration counter reaches WIDTH-1.
  - FIX to DONE unconditionally.
  - DONE to RUN on `start`, otherwise DONE to IDLE.
  - Any state to IDLE on `flush`.
- On accept, latch:
  - the magnitudes `|a|` and `|b|` (two's-complement negate when `is_signed` and the MSB is set);
  - `sign_q` = `a`[MSB] XOR `b`[MSB];
  - `sign_r` = `a`[MSB];
  - the `b == 0` flag.
- Both sign flags are forced to 0 when `is_signed` = 0.
- RUN iteration, using a 2·WIDTH+1-bit partial-remainder/quotient shift register:
  - shift left by 1;
  - trial-subtract `|b|` from the upper WIDTH+1 bits;
  - if the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
  - The counter runs 0..WIDTH-1.
- FIX:
  - `quo` = `sign_q` ? −Q : Q.
  - `rem` = `sign_r` ? −R : R.
- Divide by zero (`b == 0`) overrides the FIX result in both modes: `quo` = all ones, `rem` = `a` as sampled. No exception is raised.
- Signed overflow (−2^(WIDTH−1) / −1): `quo` = 0x80000000, `rem` = 0, with no special case.
- `flush`:
  - next state is IDLE and `done` is not pulsed;
  - `quo` and `rem` keep their prior values.
  - `flush` and `start` in the same cycle: `flush` wins and the operation is not accepted.
- `start` while `busy`: ignored.
- `resetn` low mid-operation: state returns to IDLE immediately and outputs take their reset values.

## Timing
- Reset values: state = IDLE, counter = 0, `busy` = 0, `done` = 0, `quo` = 0, `rem` = 0, internal shift register = 0.
- Cycle-by-cycle, with `start` sampled high in cycle k:

  - RUN: cycles k+1 through k+WIDTH, `busy` = 1.
  - FIX: cycle k+WIDTH+1, `busy` = 1.
  - DONE: cycle k+WIDTH+2, `done` = 1, `quo`/`rem` valid.
- Latency is WIDTH+2 cycles (34 for WIDTH = 32).
- Back-to-back: `start` in the DONE cycle enters RUN in the next cycle, giving a throughput of one result per WIDTH+2 cycles.
- `quo` and `rem` are registered. They update only on the FIX→DONE edge.

## Structure
- Add `DIV_CONTROL` and `DIVU_CONTROL` to the shared defines header, alongside the existing `*_CONTROL` ALU codes. The execute stage derives `start` and `is_signed` from these codes.
- Put the state encodings (2 bits) as localparams in this module.
- One sub-module, `div_step`: a combinational single iteration (shift, trial subtract, quotient bit). This keeps the datapath testable in isolation.

## Test plan
- Unsigned: `a` = 100, `b` = 7, `is_signed` = 0 → `done` at cycle k+34 with `quo` = 14, `rem` = 2. `busy` is high for cycles k+1..k+33.
- Signed: `a` = 0xFFFFFFF9 (−7), `b` = 2 → `quo` = 0xFFFFFFFD (−3), `rem` = 0xFFFFFFFF (−1).
- Signed overflow: `a` = 0x80000000, `b` = 0xFFFFFFFF → `quo` = 0x80000000, `rem` = 0.
- Divide by zero:
  - `a` = 5, `b` = 0, unsigned → `quo` = 0xFFFFFFFF, `rem` = 5.
  - Repeat signed with `a` = 0xFFFFFFFB → `quo` = 0xFFFFFFFF, `rem` = 0xFFFFFFFB.
- Flush and reset:
  - `flush` at cycle k+10 → IDLE at k+11, `busy` = 0, no `done`, `quo`/`rem` equal to the previous result.
  - `resetn` low at cycle k+20 → all outputs 0 immediately.
- Back-to-back: 100/7 followed by 9/3 with `start` in the DONE cycle → second `done` 34 cycles later with `quo` = 3, `rem` = 0. A `start` pulsed during RUN is ignored.
